// File: rtl/router_sched_pkg.sv
// router_pkg: shared types, widths and helpers for the router scheduler
package router_pkg;
  localparam int NUM_PORTS = 4;
  localparam int ADDR_W = 2;
  typedef enum logic {IDLE, BURST} sched_state_t;
  function automatic logic port_ready(input logic [ADDR_W-1:0] addr, input logic [NUM_PORTS-1:0] dest_ready);
    return dest_ready[addr];
  endfunction
endpackage

// File: rtl/router_sched_if.sv
// router_sched_if: requester handshake plus router-side outputs
interface router_sched_if import router_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req_valid;
  logic [ADDR_W*NUM_REQ-1:0] req_addr;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_PORTS-1:0] dest_ready;
  logic [DATA_WIDTH-1:0] din;
  logic din_en;
  logic [ADDR_W-1:0] addr;
  logic busy;
  modport master (output req_valid, req_addr, req_data, req_last, dest_ready,
                  input req_ready, din, din_en, addr, busy);
  modport slave (input req_valid, req_addr, req_data, req_last, dest_ready,
                 output req_ready, din, din_en, addr, busy);
endinterface

// File: rtl/router_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible index at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);
  // scan from farthest to nearest so the nearest eligible index wins
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (elig[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
    any = |elig;
    grant = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/router_sched.sv
// router_sched: round-robin burst scheduler feeding a 4-port address-decoded router
module router_sched import router_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ = 4
) (
  input logic clk,
  input logic reset,
  router_sched_if.slave bus
);
  localparam int W = $clog2(NUM_REQ);
  sched_state_t state;
  logic [W-1:0] rr_ptr, owner, g_idx, cur;
  logic [ADDR_W-1:0] burst_addr, beat_addr;
  logic [NUM_REQ-1:0] elig, grant;
  logic g_any, xfer;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    assign elig[i] = bus.req_valid[i] & port_ready(bus.req_addr[ADDR_W*i +: ADDR_W], bus.dest_ready);
  end
  rr_arbiter #(.N(NUM_REQ)) u_arb (.elig(elig), .ptr(rr_ptr), .grant(grant), .idx(g_idx), .any(g_any));
  // in a burst only the owner may move, always toward the latched destination
  always_comb begin
    cur = (state == IDLE) ? g_idx : owner;
    beat_addr = (state == IDLE) ? bus.req_addr[ADDR_W*g_idx +: ADDR_W] : burst_addr;
    bus.req_ready = reset ? '0
                  : (state == IDLE) ? grant
                  : (bus.req_valid[owner] & port_ready(burst_addr, bus.dest_ready)) ? (NUM_REQ'(1) << owner) : '0;
    xfer = |bus.req_ready;
  end
  assign bus.busy = (state == BURST);
  // scheduler FSM and registered router drive
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      burst_addr <= '0;
      bus.din <= '0;
      bus.din_en <= 1'b0;
      bus.addr <= '0;
    end else begin
      bus.din_en <= xfer;
      if (xfer) begin
        bus.din <= bus.req_data[DATA_WIDTH*cur +: DATA_WIDTH];
        bus.addr <= beat_addr;
        state <= bus.req_last[cur] ? IDLE : BURST;
      end
      if (xfer && state == IDLE) begin
        owner <= g_idx;
        burst_addr <= beat_addr;
        rr_ptr <= (g_idx == W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_router_sched.sv
// tb_router_sched: directed checks of arbitration, bursts, backpressure and reset
module tb_router_sched;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  router_sched_if #(.DATA_WIDTH(32), .NUM_REQ(4)) bus ();
  router_sched #(.DATA_WIDTH(32), .NUM_REQ(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic setr(input int i, input logic v, input logic [1:0] a, input logic [31:0] d, input logic l);
    bus.req_valid[i] = v;
    bus.req_addr[2*i +: 2] = a;
    bus.req_data[32*i +: 32] = d;
    bus.req_last[i] = l;
  endtask
  task automatic out(input string tag, input logic en, input logic [31:0] d, input logic [1:0] a, input logic b);
    chk({tag, ".din_en"}, 64'(bus.din_en), 64'(en));
    chk({tag, ".din"}, 64'(bus.din), 64'(d));
    chk({tag, ".addr"}, 64'(bus.addr), 64'(a));
    chk({tag, ".busy"}, 64'(bus.busy), 64'(b));
  endtask
  initial begin
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.dest_ready = 4'b1111;
    tick();
    tick();
    setr(0, 1, 2'd1, 32'h99, 1);
    settle();
    chk("rst.ready", 64'(bus.req_ready), 64'h0);
    out("rst", 0, 0, 0, 0);
    chk("rst.ptr", 64'(dut.rr_ptr), 64'h0);
    tick();
    reset = 1'b0;
    chk("rst.noaccept", 64'(bus.din_en), 64'h0);
    for (int i = 0; i < 4; i++) setr(i, 1, 2'd1, 32'h10 + i, 1);
    settle();
    chk("rr.g0", 64'(bus.req_ready), 64'b0001);
    tick(); out("rr.o0", 1, 32'h10, 1, 0); setr(0, 0, 1, 0, 1); settle();
    chk("rr.g1", 64'(bus.req_ready), 64'b0010);
    tick(); out("rr.o1", 1, 32'h11, 1, 0); setr(1, 0, 1, 0, 1); settle();
    chk("rr.g2", 64'(bus.req_ready), 64'b0100);
    tick(); out("rr.o2", 1, 32'h12, 1, 0); setr(2, 0, 1, 0, 1); settle();
    chk("rr.g3", 64'(bus.req_ready), 64'b1000);
    tick(); out("rr.o3", 1, 32'h13, 1, 0); setr(3, 0, 1, 0, 1); settle();
    chk("rr.none", 64'(bus.req_ready), 64'h0);
    chk("rr.ptr", 64'(dut.rr_ptr), 64'h0);
    tick(); out("rr.hold", 0, 32'h13, 1, 0);
    bus.dest_ready = 4'b1101;
    setr(0, 1, 2'd1, 32'h20, 1);
    setr(1, 1, 2'd2, 32'h21, 1);
    settle();
    chk("skip.g1", 64'(bus.req_ready), 64'b0010);
    tick(); out("skip.o1", 1, 32'h21, 2, 0); setr(1, 0, 0, 0, 0); settle();
    chk("skip.wait", 64'(bus.req_ready), 64'h0);
    chk("skip.ptr", 64'(dut.rr_ptr), 64'h2);
    tick(); out("skip.idle", 0, 32'h21, 2, 0);
    bus.dest_ready = 4'b1111; settle();
    chk("skip.g0", 64'(bus.req_ready), 64'b0001);
    tick(); out("skip.o0", 1, 32'h20, 1, 0); setr(0, 0, 0, 0, 0);
    chk("skip.ptr2", 64'(dut.rr_ptr), 64'h1);
    setr(2, 1, 2'd3, 32'hA, 0); settle();
    chk("bur.gA", 64'(bus.req_ready), 64'b0100);
    tick(); out("bur.oA", 1, 32'hA, 3, 1);
    setr(2, 1, 2'd0, 32'hB, 0);
    setr(0, 1, 2'd2, 32'h55, 1);
    settle();
    chk("bur.gB", 64'(bus.req_ready), 64'b0100);
    tick(); out("bur.oB", 1, 32'hB, 3, 1); setr(2, 1, 2'd0, 32'hC, 1); settle();
    chk("bur.gC", 64'(bus.req_ready), 64'b0100);
    tick(); out("bur.oC", 1, 32'hC, 3, 0); setr(2, 0, 0, 0, 0); settle();
    chk("bur.g0", 64'(bus.req_ready), 64'b0001);
    tick(); out("bur.o0", 1, 32'h55, 2, 0); setr(0, 0, 0, 0, 0);
    chk("bur.ptr", 64'(dut.rr_ptr), 64'h1);
    setr(1, 1, 2'd0, 32'h31, 0); settle();
    chk("stl.g1", 64'(bus.req_ready), 64'b0010);
    tick(); out("stl.o1", 1, 32'h31, 0, 1);
    setr(1, 1, 2'd0, 32'h32, 0);
    bus.dest_ready = 4'b1110; settle();
    chk("stl.s1", 64'(bus.req_ready), 64'h0);
    tick(); out("stl.w1", 0, 32'h31, 0, 1); settle();
    chk("stl.s2", 64'(bus.req_ready), 64'h0);
    tick(); out("stl.w2", 0, 32'h31, 0, 1);
    bus.dest_ready = 4'b1111; settle();
    chk("stl.g2", 64'(bus.req_ready), 64'b0010);
    tick(); out("stl.o2", 1, 32'h32, 0, 1); setr(1, 1, 2'd0, 32'h33, 1); settle();
    chk("stl.g3", 64'(bus.req_ready), 64'b0010);
    tick(); out("stl.o3", 1, 32'h33, 0, 0); setr(1, 0, 0, 0, 0);
    chk("stl.ptr", 64'(dut.rr_ptr), 64'h2);
    setr(3, 1, 2'd2, 32'h41, 0); settle();
    chk("mrst.g3", 64'(bus.req_ready), 64'b1000);
    tick(); out("mrst.o3", 1, 32'h41, 2, 1);
    reset = 1'b1;
    setr(3, 1, 2'd2, 32'h42, 0);
    setr(1, 1, 2'd1, 32'h51, 1);
    settle();
    chk("mrst.noready", 64'(bus.req_ready), 64'h0);
    tick(); out("mrst.after", 0, 0, 0, 0);
    chk("mrst.ptr", 64'(dut.rr_ptr), 64'h0);
    reset = 1'b0; settle();
    chk("mrst.g1", 64'(bus.req_ready), 64'b0010);
    tick(); out("mrst.o1", 1, 32'h51, 1, 0); setr(1, 0, 0, 0, 0); settle();
    chk("mrst.g3b", 64'(bus.req_ready), 64'b1000);
    tick(); out("mrst.o42", 1, 32'h42, 2, 1); setr(3, 1, 2'd1, 32'h43, 1); settle();
    chk("mrst.g3c", 64'(bus.req_ready), 64'b1000);
    tick(); out("mrst.o43", 1, 32'h43, 2, 0); setr(3, 0, 0, 0, 0);
    tick(); out("end.idle", 0, 32'h43, 2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
